dunc16_mem_resp: RTL and testbench

- Memory responder for the dunc16 CPU bus: the target end of the CPU's address/data/write interface.
- Accepts one read or write request at a time over a four-phase REQ/ACK handshake and services it from an internal word-addressed RAM.
- Inserts a programmable number of wait states and flags out-of-range addresses.
- Sits between the dunc16 core (ADDRESS, MD_OUT, WRITE) and the rest of the system; replaces the core's implicit zero-latency memory.

---
 rtl/dunc16_pkg.sv | 18 +
 rtl/dunc16_ram.sv | 27 ++
 rtl/dunc16_mem_resp.sv | 125 ++++++++++++
 tb/tb_dunc16_mem_resp.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dunc16_pkg.sv
// dunc16_pkg: shared types and constants for the dunc16 memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dunc16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACKED  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int WAIT_MAX   = 15;
  // Wait counter is sized for the largest legal wait-state setting.
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/dunc16_ram.sv
// dunc16_ram: single-port synchronous RAM, read-first, no reset on the array.
// Latency: write commits on the clock edge; Q shows mem[A] one edge after A.
// Backpressure: none, accepts an access every cycle.
// Ports: CLK clock; WE write enable; A word address; D write data; Q read data.
module dunc16_ram
  import dunc16_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[A] <= D;
    end
    Q <= mem[A];
  end

endmodule

// File: rtl/dunc16_mem_resp.sv
// dunc16_mem_resp: target-side memory responder for the dunc16 CPU bus.
// Latency: ACK WAIT_STATES+1 edges after capture; out-of-range ACKs on the capture edge.
// Backpressure: four-phase REQ/ACK, one request in flight, ACK held until REQ drops.
// Ports: CLK, RESET (async, active low); REQ/WRITE/ADDRESS/WDATA request side;
//        RDATA (read data), ACK (done), ERR (address out of range), BUSY (not idle).
module dunc16_mem_resp
  import dunc16_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WRITE,
  input  logic [15:0]       ADDRESS,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              ACK,
  output logic              ERR,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_write;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_err;
  logic              addr_oor;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_q;

  // Upper address bits are checked, never dropped: no aliasing onto the RAM.
  assign addr_oor = (ADDRESS >> ADDR_W) != 16'h0000;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (REQ) begin
          if (addr_oor)              state_nxt = ACKED;
          else if (WAIT_STATES == 0) state_nxt = ACCESS;
          else                       state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == '0) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACKED;
      ACKED:   if (!REQ) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and RAM controls
  always_comb begin
    ACK    = (state == ACKED);
    ERR    = (state == ACKED) && cap_err;
    BUSY   = (state != IDLE);
    ram_we = (state == ACCESS) && cap_write;
    // The RAM read is launched on the capture edge (live address) and then
    // repeated from the captured address, so Q already holds mem[addr] during
    // ACCESS even with zero wait states.
    ram_a  = (state == IDLE) ? ADDRESS[ADDR_W-1:0] : cap_addr;
  end

  // Capture registers, wait counter, read data
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      RDATA     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ) begin
            cap_addr  <= ADDRESS[ADDR_W-1:0];
            cap_write <= WRITE;
            cap_wdata <= WDATA;
            cap_err   <= addr_oor;
            cnt       <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        ACCESS: begin
          // Only reads update RDATA; a write leaves the last read value visible.
          if (!cap_write) RDATA <= ram_q;
        end
        default: ;
      endcase
    end
  end

  dunc16_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLK (CLK),
    .WE  (ram_we),
    .A   (ram_a),
    .D   (cap_wdata),
    .Q   (ram_q)
  );

endmodule

// File: tb/tb_dunc16_mem_resp.sv
// tb_dunc16_mem_resp: bench for the dunc16 memory responder.
// Latency: three instances with 2, 0 and 3 wait states share clock and reset.
// Backpressure: the bench holds REQ until ACK, then drops it.
module tb_dunc16_mem_resp;

  typedef struct {
    int          lat;
    logic        e;
    logic        chk;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
    logic        e;
    logic        chk;
    logic [15:0] rd;
  } txn_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic        req   [3];
  logic        wr    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  // index 0: 2 wait states, index 1: 0 wait states, index 2: 3 wait states
  dunc16_mem_resp #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(2)) u_w2 (
    .CLK(CLK), .RESET(RESET), .REQ(req[0]), .WRITE(wr[0]), .ADDRESS(addr[0]),
    .WDATA(wdata[0]), .RDATA(rdata[0]), .ACK(ack[0]), .ERR(err[0]), .BUSY(busy[0]));
  dunc16_mem_resp #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) u_w0 (
    .CLK(CLK), .RESET(RESET), .REQ(req[1]), .WRITE(wr[1]), .ADDRESS(addr[1]),
    .WDATA(wdata[1]), .RDATA(rdata[1]), .ACK(ack[1]), .ERR(err[1]), .BUSY(busy[1]));
  dunc16_mem_resp #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(3)) u_w3 (
    .CLK(CLK), .RESET(RESET), .REQ(req[2]), .WRITE(wr[2]), .ADDRESS(addr[2]),
    .WDATA(wdata[2]), .RDATA(rdata[2]), .ACK(ack[2]), .ERR(err[2]), .BUSY(busy[2]));

  // Drive a request at a falling edge and record what the response must be.
  task automatic start_req(input int k, input txn_t t);
    exp_t x;
    @(negedge CLK);
    wr[k] = t.w; addr[k] = t.a; wdata[k] = t.d; req[k] = 1'b1;
    x.lat = t.lat; x.e = t.e; x.chk = t.chk; x.rd = t.rd;
    sb.push_back(x);
  endtask

  // Edges counted from the capture edge (0) until ACK; -1 if it never comes.
  task automatic await_ack(input int k, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); #1;
      if (ack[k] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic end_req(input int k);
    @(negedge CLK);
    req[k] = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({ack[k], err[k], busy[k]} !== 3'b000) begin
        n_bad++; $display("FAIL rst_flags[%0d]: got %b want 000", k, {ack[k], err[k], busy[k]});
      end
      n_cmp++;
      if (rdata[k] !== 16'h0000) begin
        n_bad++; $display("FAIL rst_rdata[%0d]: got %h want 0000", k, rdata[k]);
      end
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if ({ack[k], err[k], busy[k], rdata[k]} !== 19'h0) begin
          n_bad++;
          $display("FAIL idle[%0d/%0d]: ack/err/busy=%b rdata=%h want 000/0000",
                   c, k, {ack[k], err[k], busy[k]}, rdata[k]);
        end
      end
    end
  endtask

  task automatic test_write_read;
    txn_t tt[3];
    exp_t e;
    int   lat;
    tt[0] = '{1'b1, 16'h0012, 16'hBEEF, 3, 1'b0, 1'b0, 16'h0000};
    tt[1] = '{1'b0, 16'h0012, 16'h0000, 3, 1'b0, 1'b1, 16'hBEEF};
    tt[2] = '{1'b1, 16'h00FF, 16'hC0DE, 3, 1'b0, 1'b1, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      start_req(0, tt[i]);
      await_ack(0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL wr_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (err[0] !== e.e) begin n_bad++; $display("FAIL wr_err[%0d]: got %b want %b", i, err[0], e.e); end
      if (e.chk) begin
        n_cmp++; if (rdata[0] !== e.rd) begin n_bad++; $display("FAIL wr_rdata[%0d]: got %h want %h", i, rdata[0], e.rd); end
      end
      end_req(0);
      n_cmp++; if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL wr_ackfall[%0d]: got %b want 0", i, ack[0]); end
    end
    n_cmp++; if (rdata[0] !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want beef", rdata[0]); end
  endtask

  task automatic test_out_of_range;
    txn_t tt[6];
    exp_t e;
    int   lat;
    tt[0] = '{1'b1, 16'h0000, 16'h0F0F, 3, 1'b0, 1'b0, 16'h0000};
    tt[1] = '{1'b1, 16'h0100, 16'hDEAD, 0, 1'b1, 1'b0, 16'h0000};
    tt[2] = '{1'b0, 16'h0000, 16'h0000, 3, 1'b0, 1'b1, 16'h0F0F};
    tt[3] = '{1'b0, 16'hFF00, 16'h0000, 0, 1'b1, 1'b1, 16'h0F0F};
    tt[4] = '{1'b1, 16'h8000, 16'h1111, 0, 1'b1, 1'b0, 16'h0000};
    tt[5] = '{1'b0, 16'h0000, 16'h0000, 3, 1'b0, 1'b1, 16'h0F0F};
    for (int i = 0; i < 6; i++) begin
      start_req(0, tt[i]);
      await_ack(0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL oor_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (err[0] !== e.e) begin n_bad++; $display("FAIL oor_err[%0d]: got %b want %b", i, err[0], e.e); end
      if (e.chk) begin
        n_cmp++; if (rdata[0] !== e.rd) begin n_bad++; $display("FAIL oor_rdata[%0d]: got %h want %h", i, rdata[0], e.rd); end
      end
      end_req(0);
      n_cmp++; if ({ack[0], err[0]} !== 2'b00) begin n_bad++; $display("FAIL oor_ackfall[%0d]: got %b want 00", i, {ack[0], err[0]}); end
    end
  endtask

  task automatic test_zero_wait;
    txn_t tt[4];
    exp_t e;
    int   lat;
    tt[0] = '{1'b1, 16'h0005, 16'h1234, 1, 1'b0, 1'b0, 16'h0000};
    tt[1] = '{1'b0, 16'h0005, 16'h0000, 1, 1'b0, 1'b1, 16'h1234};
    tt[2] = '{1'b1, 16'h0005, 16'hABCD, 1, 1'b0, 1'b0, 16'h0000};
    tt[3] = '{1'b0, 16'h0005, 16'h0000, 1, 1'b0, 1'b1, 16'hABCD};
    for (int i = 0; i < 4; i++) begin
      start_req(1, tt[i]);
      await_ack(1, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL zw_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (err[1] !== e.e) begin n_bad++; $display("FAIL zw_err[%0d]: got %b want %b", i, err[1], e.e); end
      if (e.chk) begin
        n_cmp++; if (rdata[1] !== e.rd) begin n_bad++; $display("FAIL zw_rdata[%0d]: got %h want %h", i, rdata[1], e.rd); end
      end
      end_req(1);
      n_cmp++; if (ack[1] !== 1'b0) begin n_bad++; $display("FAIL zw_ackfall[%0d]: got %b want 0", i, ack[1]); end
    end
  endtask

  task automatic test_reset_mid_txn;
    txn_t tt[2];
    txn_t t;
    exp_t e;
    int   lat;
    // seed address 7 with the old value
    t = '{1'b1, 16'h0007, 16'h5555, 4, 1'b0, 1'b0, 16'h0000};
    start_req(2, t);
    await_ack(2, lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rmw_seed_lat: got %0d want %0d", lat, e.lat); end
    end_req(2);
    // overwrite attempt, killed by reset while waiting
    @(negedge CLK);
    wr[2] = 1'b1; addr[2] = 16'h0007; wdata[2] = 16'hAAAA; req[2] = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    n_cmp++; if ({busy[2], ack[2]} !== 2'b10) begin n_bad++; $display("FAIL rmw_in_wait: busy/ack=%b want 10", {busy[2], ack[2]}); end
    RESET = 1'b0;
    #1;
    n_cmp++; if ({busy[2], ack[2]} !== 2'b00) begin n_bad++; $display("FAIL rmw_async_rst: busy/ack=%b want 00", {busy[2], ack[2]}); end
    n_cmp++; if (rdata[0] !== 16'h0000) begin n_bad++; $display("FAIL rmw_rdata_clr: got %h want 0000", rdata[0]); end
    @(negedge CLK);
    req[2] = 1'b0;
    RESET  = 1'b1;
    // a write that has passed its access edge survives a reset
    t = '{1'b1, 16'h0008, 16'h7777, 4, 1'b0, 1'b0, 16'h0000};
    start_req(2, t);
    await_ack(2, lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rmw_post_lat: got %0d want %0d", lat, e.lat); end
    RESET = 1'b0;
    #1;
    n_cmp++; if (ack[2] !== 1'b0) begin n_bad++; $display("FAIL rmw_post_rst_ack: got %b want 0", ack[2]); end
    @(negedge CLK);
    req[2] = 1'b0;
    RESET  = 1'b1;
    tt[0] = '{1'b0, 16'h0007, 16'h0000, 4, 1'b0, 1'b1, 16'h5555};
    tt[1] = '{1'b0, 16'h0008, 16'h0000, 4, 1'b0, 1'b1, 16'h7777};
    for (int i = 0; i < 2; i++) begin
      start_req(2, tt[i]);
      await_ack(2, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rmw_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (rdata[2] !== e.rd) begin n_bad++; $display("FAIL rmw_rdata[%0d]: got %h want %h", i, rdata[2], e.rd); end
      end_req(2);
    end
  endtask

  task automatic test_held_and_early_drop;
    txn_t t;
    exp_t e;
    int   lat;
    int   pulses;
    logic [15:0] rd_at_ack;
    // REQ held well past ACK
    t = '{1'b1, 16'h0030, 16'h4242, 3, 1'b0, 1'b0, 16'h0000};
    start_req(0, t);
    await_ack(0, lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL held_lat: got %0d want %0d", lat, e.lat); end
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      n_cmp++; if ({ack[0], busy[0]} !== 2'b11) begin n_bad++; $display("FAIL held_ack[%0d]: ack/busy=%b want 11", c, {ack[0], busy[0]}); end
    end
    end_req(0);
    n_cmp++; if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL held_ackfall: got %b want 0", ack[0]); end
    @(posedge CLK); #1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL held_no_second: busy=%b want 0", busy[0]); end
    // REQ dropped while the request is still waiting
    t = '{1'b0, 16'h0030, 16'h0000, 3, 1'b0, 1'b1, 16'h4242};
    start_req(0, t);
    @(posedge CLK);
    @(negedge CLK);
    req[0] = 1'b0;
    lat = -1; pulses = 0; rd_at_ack = 16'h0000;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      if (ack[0] === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          rd_at_ack = rdata[0];
        end
      end
    end
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL drop_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    n_cmp++; if (rd_at_ack !== e.rd) begin n_bad++; $display("FAIL drop_rdata: got %h want %h", rd_at_ack, e.rd); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL drop_idle: busy=%b want 0", busy[0]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = 16'h0000; wdata[k] = 16'h0000;
    end
    #1;
    RESET = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_zero_wait();
    test_reset_mid_txn();
    test_held_and_early_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
